ste_ram_arb: RTL and testbench

STE_RAM_ARB -- requirements
Module: ste_ram_arb

---
 rtl/ste_ram_arb.sv | 164 ++++++++++++++++
 tb/tb_ste_ram_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ste_ram_arb.sv
// STE shared-RAM slot arbiter: 8-clk32 slots alternate even (video/sound/refresh) and odd (CPU/blitter).
// Blitter arbitration is compiled in only when STE_BLITTER_EN is defined.
//
// blitter state | meaning
// BLT_IDLE      | no ownership, blitter may claim an odd slot when CPU is idle
// BLT_OWN       | blitter owns odd slots, blt_cnt counts granted slots
// BLT_WIN       | guaranteed CPU window, blt_cnt counts window slots
module ste_ram_arb (
    input  logic       clk32,
    input  logic       resb,
    input  logic       vid_req,
    input  logic       snd_req,
    input  logic       ref_req,
    input  logic       cpu_req,
    input  logic       blt_req,
    output logic       vid_gnt,
    output logic       snd_gnt,
    output logic       ref_gnt,
    output logic       cpu_gnt,
    output logic       blt_gnt,
    output logic [2:0] slot_ph,
    output logic       slot_odd,
    output logic       cyc_start
);

    logic       decide;
    logic [1:0] ref_age;
    logic       ev_vid;
    logic       ev_snd;
    logic       ev_ref;
    logic       od_cpu;

    assign decide = (slot_ph == 3'd7);

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            slot_ph   <= 3'd0;
            slot_odd  <= 1'b0;
            cyc_start <= 1'b0;
        end else begin
            slot_ph   <= slot_ph + 3'd1;
            cyc_start <= decide;
            if (decide) begin
                slot_odd <= ~slot_odd;
            end
        end
    end

    // An aged refresh overtakes sound but never video.
    always_comb begin
        ev_vid = vid_req;
        ev_ref = 1'b0;
        ev_snd = 1'b0;
        if (!vid_req) begin
            if (ref_req && ((ref_age == 2'd3) || !snd_req)) begin
                ev_ref = 1'b1;
            end else begin
                ev_snd = snd_req;
            end
        end
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            ref_age <= 2'd0;
        end else if (decide && slot_odd) begin
            if (!ref_req || ev_ref) begin
                ref_age <= 2'd0;
            end else if (ref_age != 2'd3) begin
                ref_age <= ref_age + 2'd1;
            end
        end
    end

`ifdef STE_BLITTER_EN
    localparam logic [1:0] BLT_IDLE = 2'd0;
    localparam logic [1:0] BLT_OWN  = 2'd1;
    localparam logic [1:0] BLT_WIN  = 2'd2;

    logic [1:0] blt_st;
    logic [1:0] blt_st_nxt;
    logic [5:0] blt_cnt;
    logic [5:0] blt_cnt_nxt;
    logic       blt_own;
    logic       blt_win;
    logic       od_blt;

    assign blt_own = (blt_st == BLT_OWN);
    assign blt_win = (blt_st == BLT_WIN);

    // blt_cnt is shared: owned-slot count while owning, window-slot count during the CPU window.
    always_comb begin
        blt_st_nxt  = blt_st;
        blt_cnt_nxt = blt_cnt;
        od_blt      = 1'b0;
        od_cpu      = cpu_req;
        if (blt_own) begin
            if (!blt_req) begin
                blt_st_nxt  = BLT_IDLE;
                blt_cnt_nxt = 6'd0;
            end else begin
                od_blt = 1'b1;
                od_cpu = 1'b0;
                if (blt_cnt == 6'd63) begin
                    blt_st_nxt  = BLT_WIN;
                    blt_cnt_nxt = 6'd0;
                end else begin
                    blt_cnt_nxt = blt_cnt + 6'd1;
                end
            end
        end else if (blt_win) begin
            if (blt_cnt == 6'd63) begin
                blt_st_nxt  = BLT_IDLE;
                blt_cnt_nxt = 6'd0;
            end else begin
                blt_cnt_nxt = blt_cnt + 6'd1;
            end
        end else if (blt_req && !cpu_req) begin
            od_blt      = 1'b1;
            od_cpu      = 1'b0;
            blt_st_nxt  = BLT_OWN;
            blt_cnt_nxt = 6'd1;
        end
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            blt_st  <= BLT_IDLE;
            blt_cnt <= 6'd0;
        end else if (decide && !slot_odd) begin
            blt_st  <= blt_st_nxt;
            blt_cnt <= blt_cnt_nxt;
        end
    end
`else
    logic unused_blt_req;

    assign unused_blt_req = blt_req;
    assign od_cpu         = cpu_req;
    assign blt_gnt        = 1'b0;
`endif

    // Grants are decided at phase 7 and held for the whole following slot.
    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            vid_gnt <= 1'b0;
            snd_gnt <= 1'b0;
            ref_gnt <= 1'b0;
            cpu_gnt <= 1'b0;
`ifdef STE_BLITTER_EN
            blt_gnt <= 1'b0;
`endif
        end else if (decide) begin
            vid_gnt <= slot_odd & ev_vid;
            snd_gnt <= slot_odd & ev_snd;
            ref_gnt <= slot_odd & ev_ref;
            cpu_gnt <= ~slot_odd & od_cpu;
`ifdef STE_BLITTER_EN
            blt_gnt <= ~slot_odd & od_blt;
`endif
        end
    end

endmodule

// File: tb/tb_ste_ram_arb.sv
// Bench for ste_ram_arb: a slot-level reference model feeds a grant scoreboard, plus directed slot sequences.
// Blitter sequences are exercised when STE_BLITTER_EN is defined.
`timescale 1ns/1ps
module tb_ste_ram_arb;

    localparam logic [4:0] G_NONE = 5'b00000;
    localparam logic [4:0] G_VID  = 5'b10000;
    localparam logic [4:0] G_SND  = 5'b01000;
    localparam logic [4:0] G_REF  = 5'b00100;
    localparam logic [4:0] G_CPU  = 5'b00010;
    localparam logic [4:0] G_BLT  = 5'b00001;

    logic       clk32 = 1'b0;
    logic       resb = 1'b1;
    logic       vid_req = 1'b0;
    logic       snd_req = 1'b0;
    logic       ref_req = 1'b0;
    logic       cpu_req = 1'b0;
    logic       blt_req = 1'b0;
    logic       vid_gnt, snd_gnt, ref_gnt, cpu_gnt, blt_gnt;
    logic [2:0] slot_ph;
    logic       slot_odd;
    logic       cyc_start;
    logic [4:0] gnt;

    int n_checks = 0;
    int n_errors = 0;

    ste_ram_arb dut (
        .clk32     (clk32),
        .resb      (resb),
        .vid_req   (vid_req),
        .snd_req   (snd_req),
        .ref_req   (ref_req),
        .cpu_req   (cpu_req),
        .blt_req   (blt_req),
        .vid_gnt   (vid_gnt),
        .snd_gnt   (snd_gnt),
        .ref_gnt   (ref_gnt),
        .cpu_gnt   (cpu_gnt),
        .blt_gnt   (blt_gnt),
        .slot_ph   (slot_ph),
        .slot_odd  (slot_odd),
        .cyc_start (cyc_start)
    );

    always #15.625 clk32 = ~clk32;

    assign gnt = {vid_gnt, snd_gnt, ref_gnt, cpu_gnt, blt_gnt};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, advanced on the same edges as the DUT.
    int         m_ph    = 0;
    bit         m_odd   = 1'b0;
    bit         m_seen7 = 1'b0;
    int         m_age   = 0;
    int         m_bst   = 0;
    int         m_bcnt  = 0;
    logic [4:0] m_cur   = G_NONE;
    logic [4:0] sb_q[$];

    task automatic model_decide(output logic [4:0] g);
        g = G_NONE;
        if (m_odd) begin
            if (vid_req) g = G_VID;
            else if (ref_req && m_age == 3) g = G_REF;
            else if (snd_req) g = G_SND;
            else if (ref_req) g = G_REF;
            if (ref_req && g != G_REF) m_age = (m_age == 3) ? 3 : m_age + 1;
            else m_age = 0;
        end else begin
`ifdef STE_BLITTER_EN
            if (m_bst == 1 && m_bcnt == 64) begin
                m_bst = 2; m_bcnt = 0;
            end else if (m_bst == 1 && !blt_req) begin
                m_bst = 0;
            end
            if (m_bst == 2 && m_bcnt == 64) begin
                m_bst = 0; m_bcnt = 0;
            end
            if (m_bst == 0 && blt_req && !cpu_req) begin
                m_bst = 1; m_bcnt = 0;
            end
            if (m_bst == 1) begin
                g = G_BLT;
                m_bcnt++;
            end else begin
                if (cpu_req) g = G_CPU;
                if (m_bst == 2) m_bcnt++;
            end
`else
            if (cpu_req) g = G_CPU;
`endif
        end
    endtask

    always @(posedge clk32 or negedge resb) begin
        logic [4:0] g;
        if (!resb) begin
            m_ph = 0; m_odd = 1'b0; m_seen7 = 1'b0; m_age = 0; m_bst = 0; m_bcnt = 0;
            sb_q.delete();
        end else begin
            if (m_ph == 7) begin
                model_decide(g);
                sb_q.push_back(g);
                m_seen7 = 1'b1;
            end
            m_ph = (m_ph + 1) % 8;
            if (m_ph == 0) m_odd = !m_odd;
        end
    end

    // Scoreboard: a new expectation is popped at phase 0 and must hold for the whole slot.
    always @(negedge clk32) begin
        if (!resb) begin
            m_cur = G_NONE;
            check_val("rst_gnt", 32'(gnt), 32'(G_NONE));
            check_val("rst_slot_ph", 32'(slot_ph), 32'd0);
            check_val("rst_cyc_start", 32'(cyc_start), 32'd0);
        end else begin
            if (m_ph == 0) begin
                if (sb_q.size() > 0) m_cur = sb_q.pop_front();
                else m_cur = G_NONE;
            end
            check_val("sb_gnt", 32'(gnt), 32'(m_cur));
            check_val("sb_slot_ph", 32'(slot_ph), 32'(m_ph));
            check_val("sb_slot_odd", 32'(slot_odd), 32'(m_odd));
            check_val("sb_cyc_start", 32'(cyc_start), 32'(m_ph == 0 && m_seen7));
        end
    end

    task automatic do_reset(input logic v, input logic s, input logic r, input logic c, input logic b);
        @(negedge clk32);
        #2 resb = 1'b0;
        vid_req = v; snd_req = s; ref_req = r; cpu_req = c; blt_req = b;
        repeat (2) @(negedge clk32);
        resb = 1'b1;
    endtask

    // Advance to phase 1 of the next slot with the given parity.
    task automatic wait_slot(input bit odd, input string tag);
        int k = 0;
        do begin
            @(negedge clk32);
            k++;
        end while (!(slot_ph == 3'd1 && slot_odd == odd) && k < 40);
        if (k >= 40) check_val({tag, "_slot_wait"}, 32'({slot_odd, slot_ph}), 32'({odd, 3'd1}));
    endtask

    logic [4:0] seq026 [5];

    initial begin
        int cs_cnt;
        int k;
        #5 resb = 1'b0;
        #10;
        check_val("reset_gnt", 32'(gnt), 32'(G_NONE));
        check_val("reset_ph", 32'(slot_ph), 32'd0);
        check_val("reset_odd", 32'(slot_odd), 32'd0);
        check_val("reset_cs", 32'(cyc_start), 32'd0);
        check_val("reset_age", 32'(dut.ref_age), 32'd0);

        // CPU-only start: slot 0 empty, slot 1 granted to CPU.
        cpu_req = 1'b1;
        @(negedge clk32);
        resb = 1'b1;
        wait_slot(1'b0, "r027_s0");
        check_val("r027_slot0_none", 32'(gnt), 32'(G_NONE));
        wait_slot(1'b1, "r027_s1");
        check_val("r027_slot1_cpu", 32'(gnt), 32'(G_CPU));
        cs_cnt = 0;
        repeat (64) begin
            @(negedge clk32);
            cs_cnt += int'(cyc_start);
        end
        check_val("r027_cs_pulses", 32'(cs_cnt), 32'd8);

        // Asynchronous reset in the middle of a granted slot.
        k = 0;
        do begin
            @(negedge clk32);
            k++;
        end while (!(slot_ph == 3'd4 && cpu_gnt) && k < 40);
        check_val("r029_found_ph4", 32'({cpu_gnt, slot_ph}), 32'({1'b1, 3'd4}));
        #2 resb = 1'b0;
        #1;
        check_val("r029_gnt_drop", 32'(gnt), 32'(G_NONE));
        check_val("r029_ph", 32'(slot_ph), 32'd0);
        check_val("r029_odd", 32'(slot_odd), 32'd0);
        check_val("r029_cs", 32'(cyc_start), 32'd0);
        check_val("r029_age", 32'(dut.ref_age), 32'd0);
`ifdef STE_BLITTER_EN
        check_val("r029_blt_cnt", 32'(dut.blt_cnt), 32'd0);
`endif
        repeat (2) @(negedge clk32);
        resb = 1'b1;

        // Video dominates while held; refresh dropped with video so the aged refresh does not claim the slot.
        do_reset(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_slot(1'b0, "r025_s0");
        check_val("r025_slot0_none", 32'(gnt), 32'(G_NONE));
        for (int i = 0; i < 4; i++) begin
            wait_slot(1'b0, "r025_ev");
            check_val("r025_vid", 32'(gnt), 32'(G_VID));
        end
        vid_req = 1'b0;
        ref_req = 1'b0;
        wait_slot(1'b0, "r025_rel");
        check_val("r025_snd_after", 32'(gnt), 32'(G_SND));

        // Sound vs refresh aging.
        seq026[0] = G_SND; seq026[1] = G_SND; seq026[2] = G_SND; seq026[3] = G_REF; seq026[4] = G_SND;
        do_reset(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_slot(1'b0, "r026_s0");
        for (int i = 0; i < 5; i++) begin
            wait_slot(1'b0, "r026_ev");
            check_val($sformatf("r026_even%0d", i), 32'(gnt), 32'(seq026[i]));
        end

`ifdef STE_BLITTER_EN
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_slot(1'b0, "r028_s0");
        for (int i = 0; i < 64; i++) begin
            wait_slot(1'b1, "r028_own");
            check_val($sformatf("r028_blt%0d", i), 32'(gnt), 32'(G_BLT));
            if (i == 0) cpu_req = 1'b1;
        end
        for (int i = 0; i < 64; i++) begin
            wait_slot(1'b1, "r028_win");
            check_val($sformatf("r028_win%0d", i), 32'(gnt), 32'(G_CPU));
            if (i == 63) cpu_req = 1'b0;
        end
        wait_slot(1'b1, "r028_regain");
        check_val("r028_regain", 32'(gnt), 32'(G_BLT));
        blt_req = 1'b0;
        wait_slot(1'b1, "r028_drop");
        check_val("r028_release", 32'(gnt), 32'(G_NONE));
`else
        do_reset(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_slot(1'b0, "r030_s0");
        for (int i = 0; i < 4; i++) begin
            wait_slot(1'b1, "r030_odd");
            check_val($sformatf("r030_cpu%0d", i), 32'(gnt), 32'(G_CPU));
        end
        cpu_req = 1'b0;
        wait_slot(1'b1, "r030_idle");
        check_val("r030_none", 32'(gnt), 32'(G_NONE));
`endif

        // Random requests changing at any phase; the scoreboard checks every cycle.
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3000) begin
            @(negedge clk32);
            vid_req = ($urandom_range(0, 3) == 0);
            snd_req = $urandom_range(0, 1) != 0;
            ref_req = $urandom_range(0, 1) != 0;
            cpu_req = $urandom_range(0, 1) != 0;
            blt_req = $urandom_range(0, 3) != 0;
        end
        repeat (2) @(negedge clk32);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
